lc3b_microsequencer: RTL and testbench

Microsequencer for the LC-3b microcoded control unit. It owns the micro-PC register that drives the `ControlStore` address input. Each cycle it consumes the 23-bit control word that `ControlStore` returns, together with IR and condition inputs, and computes the next micro-address. It also owns the branch-enable (BEN) register and a memory-ready watchdog.

---
 rtl/lc3b_pkg.sv | 28 ++
 rtl/mem_wait_watchdog.sv | 39 +++
 rtl/lc3b_microsequencer.sv | 83 ++++++++
 tb/tb_lc3b_microsequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_pkg.sv
// Shared constants for the LC-3b microcoded control unit: control-word layout,
// widths and the COND branch-type encoding used by the microsequencer and ControlStore.
package lc3b_pkg;

    localparam int cs_width_p  = 23;
    localparam int upc_width_p = 6;

    // Control-word field positions; bits 12:0 belong to the datapath.
    localparam int ird_bit_p    = 22;
    localparam int cond_msb_p   = 21;
    localparam int cond_lsb_p   = 20;
    localparam int j_msb_p      = 19;
    localparam int j_lsb_p      = 14;
    localparam int ld_ben_bit_p = 13;

    typedef enum logic [1:0] {
        COND_UNCOND = 2'b00,
        COND_MEM_R  = 2'b01,
        COND_BEN    = 2'b10,
        COND_ADDR11 = 2'b11
    } cond_e;

    // Decode dispatch: the opcode selects one of the first sixteen micro-states.
    function automatic logic [upc_width_p-1:0] ird_target(input logic [3:0] opcode);
        return {2'b00, opcode};
    endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Saturating count of consecutive memory-wait cycles with a sticky timeout flag.
// The flag only reports; it never stalls or redirects sequencing.
module mem_wait_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic wait_i,
    output logic timeout_o
);

    localparam logic [15:0] limit_p = 16'(TIMEOUT);

    logic [15:0] count_reg;
    logic        timeout_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg   <= 16'd0;
            timeout_reg <= 1'b0;
        end else if (en) begin
            if (wait_i) begin
                if (count_reg != limit_p) begin
                    count_reg <= count_reg + 16'd1;
                end
            end else begin
                count_reg <= 16'd0;
            end
            // A full counter arms the flag on the following enabled edge, whatever that cycle does.
            if (count_reg == limit_p) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_reg;

endmodule

// File: rtl/lc3b_microsequencer.sv
// LC-3b microsequencer: holds the micro-PC and BEN registers and computes the next
// micro-address from the current control word, IR and condition inputs.
module lc3b_microsequencer
    import lc3b_pkg::*;
#(
    parameter logic [5:0] RESET_UPC = 6'd18,
    parameter int         TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [cs_width_p-1:0]  cs_bits,
    input  logic [15:0]            ir,
    input  logic                   n,
    input  logic                   z,
    input  logic                   p,
    input  logic                   mem_r,
    output logic [upc_width_p-1:0] upc,
    output logic                   ben,
    output logic                   mem_timeout
);

    logic                   ird;
    cond_e                  cond;
    logic [upc_width_p-1:0] j_field;
    logic                   ld_ben;

    logic [upc_width_p-1:0] upc_reg;
    logic [upc_width_p-1:0] upc_next;
    logic                   ben_reg;
    logic                   ben_next;
    logic                   wait_cycle;

    assign ird     = cs_bits[ird_bit_p];
    assign cond    = cond_e'(cs_bits[cond_msb_p:cond_lsb_p]);
    assign j_field = cs_bits[j_msb_p:j_lsb_p];
    assign ld_ben  = cs_bits[ld_ben_bit_p];

    // Datapath-only fields and IR bits the sequencer never looks at.
    logic unused_bits;
    assign unused_bits = ^{cs_bits[ld_ben_bit_p-1:0], ir[8:0]};

    always_comb begin
        upc_next = j_field;
        if (ird) begin
            upc_next = ird_target(ir[15:12]);
        end else begin
            upc_next[2] = j_field[2] | ((cond == COND_BEN)    & ben_reg);
            upc_next[1] = j_field[1] | ((cond == COND_MEM_R)  & mem_r);
            upc_next[0] = j_field[0] | ((cond == COND_ADDR11) & ir[11]);
        end
    end

    assign ben_next   = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    assign wait_cycle = ~ird & (cond == COND_MEM_R) & ~mem_r;

    // Branches read the registered BEN, so a same-word load takes effect one word later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc_reg <= RESET_UPC;
            ben_reg <= 1'b0;
        end else if (en) begin
            upc_reg <= upc_next;
            if (ld_ben) begin
                ben_reg <= ben_next;
            end
        end
    end

    mem_wait_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wait_i    (wait_cycle),
        .timeout_o (mem_timeout)
    );

    assign upc = upc_reg;
    assign ben = ben_reg;

endmodule

// File: tb/tb_lc3b_microsequencer.sv
// Self-checking bench for lc3b_microsequencer: directed vector table, hand-written
// reset/watchdog sequences and a randomized run against an abstract reference model.
module tb_lc3b_microsequencer;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en;
    logic [22:0] cs_bits;
    logic [15:0] ir;
    logic        n, z, p;
    logic        mem_r;
    logic [5:0]  upc;
    logic        ben;
    logic        mem_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3b_microsequencer #(
        .RESET_UPC (6'd18),
        .TIMEOUT   (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cs_bits     (cs_bits),
        .ir          (ir),
        .n           (n),
        .z           (z),
        .p           (p),
        .mem_r       (mem_r),
        .upc         (upc),
        .ben         (ben),
        .mem_timeout (mem_timeout)
    );

    typedef struct {
        logic        en;
        logic        ird;
        logic [1:0]  cond;
        logic [5:0]  j;
        logic        ld;
        logic [15:0] ir;
        logic [2:0]  nzp;
        logic        mem_r;
        logic [12:0] junk;
        logic [5:0]  exp_upc;
        logic        exp_ben;
        logic        exp_to;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [22:0] cw(input logic ird_f, input logic [1:0] cond_f,
                                       input logic [5:0] j_f, input logic ld_f,
                                       input logic [12:0] junk_f);
        return {ird_f, cond_f, j_f, ld_f, junk_f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [22:0] c, input logic [15:0] i,
                         input logic [2:0] nzp_v, input logic m);
        en      = e;
        cs_bits = c;
        ir      = i;
        {n, z, p} = nzp_v;
        mem_r   = m;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [5:0] eu, input logic eb, input logic et);
        chk({tag, " upc"}, 32'(upc), 32'(eu));
        chk({tag, " ben"}, 32'(ben), 32'(eb));
        chk({tag, " mem_timeout"}, 32'(mem_timeout), 32'(et));
        $display("%s: upc=%0d ben=%0d mem_timeout=%0d", tag, upc, ben, mem_timeout);
    endtask

    // Async reset pulse placed mid-cycle, between rising edges.
    task automatic reset_pulse;
        #2 rst = 1'b1;
        #1;
        check_all("rst pulse", 6'd18, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic add(input logic e, input logic ird_f, input logic [1:0] c, input logic [5:0] j,
                       input logic ld, input logic [15:0] i, input logic [2:0] nzp_v, input logic m,
                       input logic [5:0] eu, input logic eb, input logic et);
        vec_t v;
        v.en = e; v.ird = ird_f; v.cond = c; v.j = j; v.ld = ld; v.ir = i; v.nzp = nzp_v;
        v.mem_r = m; v.junk = (vecs.size() % 2 == 1) ? 13'h1FFF : 13'h0000;
        v.exp_upc = eu; v.exp_ben = eb; v.exp_to = et;
        vecs.push_back(v);
    endtask

    // Reference model state (abstract: an unbounded streak of waits, not a saturating counter)
    int m_upc, m_ben, m_streak, m_to;

    function automatic int model_next(input int c_w, input int ir_v, input int mr);
        int ird_f, cond_f, j_f, nx;
        ird_f  = (c_w >> 22) & 1;
        cond_f = (c_w >> 20) & 3;
        j_f    = (c_w >> 14) & 63;
        if (ird_f == 1) return (ir_v >> 12) & 15;
        nx = j_f;
        if (cond_f == 2 && m_ben == 1)              nx = nx | 4;
        if (cond_f == 1 && mr == 1)                 nx = nx | 2;
        if (cond_f == 3 && ((ir_v >> 11) & 1) == 1) nx = nx | 1;
        return nx;
    endfunction

    initial begin
        drive(1'b0, 23'h0, 16'h0, 3'b000, 1'b0);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_all("reset state", 6'd18, 1'b0, 1'b0);

        // en  ird cond  j   ld  ir        nzp    mr   upc ben to
        add(1, 0, 2'd0, 33, 0, 16'h0000, 3'b000, 0, 33, 0, 0);
        add(0, 0, 2'd0, 10, 0, 16'h0000, 3'b000, 0, 33, 0, 0);
        add(0, 0, 2'd0, 10, 0, 16'h0000, 3'b000, 0, 33, 0, 0);
        add(0, 0, 2'd0, 10, 0, 16'h0000, 3'b000, 0, 33, 0, 0);
        add(1, 1, 2'd0, 33, 0, 16'h6000, 3'b000, 0,  6, 0, 0);
        add(1, 0, 2'd0,  5, 1, 16'h0400, 3'b010, 0,  5, 1, 0);
        add(1, 0, 2'd2, 18, 0, 16'h0000, 3'b000, 0, 22, 1, 0);
        add(1, 1, 2'd2, 18, 0, 16'h6000, 3'b000, 0,  6, 1, 0);
        add(1, 0, 2'd2, 18, 1, 16'h0400, 3'b101, 0, 22, 0, 0);
        add(1, 0, 2'd2, 18, 0, 16'h0000, 3'b000, 0, 18, 0, 0);
        add(1, 0, 2'd1, 33, 0, 16'h0000, 3'b000, 0, 33, 0, 0);
        add(1, 0, 2'd1, 33, 0, 16'h0000, 3'b000, 0, 33, 0, 0);
        add(1, 0, 2'd1, 33, 0, 16'h0000, 3'b000, 0, 33, 0, 0);
        add(1, 0, 2'd1, 33, 0, 16'h0000, 3'b000, 1, 35, 0, 0);
        add(1, 0, 2'd3, 32, 0, 16'h0800, 3'b000, 0, 33, 0, 0);
        add(1, 0, 2'd3, 32, 0, 16'h0000, 3'b000, 0, 32, 0, 0);
        add(1, 0, 2'd1, 33, 0, 16'h0000, 3'b000, 0, 33, 0, 0);
        add(1, 0, 2'd1, 33, 0, 16'h0000, 3'b000, 0, 33, 0, 0);
        add(1, 0, 2'd1, 33, 0, 16'h0000, 3'b000, 0, 33, 0, 0);
        add(1, 0, 2'd1, 33, 0, 16'h0000, 3'b000, 0, 33, 0, 0);
        add(0, 0, 2'd1, 33, 0, 16'h0000, 3'b000, 0, 33, 0, 0);
        add(1, 0, 2'd1, 33, 0, 16'h0000, 3'b000, 1, 35, 0, 1);

        foreach (vecs[k]) begin
            drive(vecs[k].en, cw(vecs[k].ird, vecs[k].cond, vecs[k].j, vecs[k].ld, vecs[k].junk),
                  vecs[k].ir, vecs[k].nzp, vecs[k].mem_r);
            tick();
            check_all($sformatf("vec %0d", k), vecs[k].exp_upc, vecs[k].exp_ben, vecs[k].exp_to);
        end

        // Async reset acts between edges and dominates en across an edge; release holds.
        #2 rst = 1'b1;
        #1;
        check_all("async rst immediate", 6'd18, 1'b0, 1'b0);
        drive(1'b1, cw(0, 2'd0, 6'd33, 0, 13'h0), 16'h0, 3'b000, 1'b0);
        tick();
        check_all("rst over edge", 6'd18, 1'b0, 1'b0);
        drive(1'b0, cw(0, 2'd0, 6'd33, 0, 13'h0), 16'h0, 3'b000, 1'b0);
        #2 rst = 1'b0;
        tick();
        check_all("release hold", 6'd18, 1'b0, 1'b0);
        drive(1'b1, cw(0, 2'd0, 6'd33, 0, 13'h0), 16'h0, 3'b000, 1'b0);
        tick();
        check_all("first enabled edge", 6'd33, 1'b0, 1'b0);

        // T+1 consecutive waits raise the flag; it sticks through mem_r.
        drive(1'b1, cw(0, 2'd1, 6'd33, 0, 13'h0), 16'h0, 3'b000, 1'b0);
        for (int w = 1; w <= T + 1; w++) begin
            tick();
            check_all($sformatf("wait %0d", w), 6'd33, 1'b0, (w == T + 1) ? 1'b1 : 1'b0);
        end
        mem_r = 1'b1;
        tick();
        check_all("sticky after mem_r", 6'd35, 1'b0, 1'b1);

        // Reset mid-wait restarts the count.
        reset_pulse();
        drive(1'b1, cw(0, 2'd1, 6'd33, 0, 13'h0), 16'h0, 3'b000, 1'b0);
        repeat (3) tick();
        reset_pulse();
        for (int w = 1; w <= T; w++) begin
            tick();
            check_all($sformatf("post-rst wait %0d", w), 6'd33, 1'b0, 1'b0);
        end

        // Ready at count T-1 clears; T more waits then still leave the flag low.
        reset_pulse();
        drive(1'b1, cw(0, 2'd1, 6'd33, 0, 13'h0), 16'h0, 3'b000, 1'b0);
        repeat (T - 1) tick();
        mem_r = 1'b1;
        tick();
        check_all("ready at T-1", 6'd35, 1'b0, 1'b0);
        mem_r = 1'b0;
        for (int w = 1; w <= T; w++) begin
            tick();
            check_all($sformatf("refill %0d", w), 6'd33, 1'b0, 1'b0);
        end

        // Randomized run against the reference model.
        reset_pulse();
        m_upc = 18; m_ben = 0; m_streak = 0; m_to = 0;
        for (int c = 0; c < 600; c++) begin
            int e, ird_f, cond_f, j_f, ld_f, ir_v, nzp_v, mr, c_w, nx, wt;
            if ($urandom_range(0, 59) == 0) begin
                reset_pulse();
                m_upc = 18; m_ben = 0; m_streak = 0; m_to = 0;
            end
            e      = ($urandom_range(0, 9) != 0) ? 1 : 0;
            ird_f  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            cond_f = ($urandom_range(0, 9) < 6) ? 1 : int'($urandom_range(0, 3));
            j_f    = int'($urandom_range(0, 63));
            ld_f   = int'($urandom_range(0, 1));
            ir_v   = int'($urandom_range(0, 65535));
            nzp_v  = int'($urandom_range(0, 7));
            mr     = ($urandom_range(0, 5) == 0) ? 1 : 0;
            c_w    = (ird_f << 22) | (cond_f << 20) | (j_f << 14) | (ld_f << 13)
                   | int'($urandom_range(0, 8191));
            drive(e[0], 23'(c_w), 16'(ir_v), 3'(nzp_v), mr[0]);
            if (e == 1) begin
                nx = model_next(c_w, ir_v, mr);
                wt = (ird_f == 0 && cond_f == 1 && mr == 0) ? 1 : 0;
                if (m_streak >= T) m_to = 1;
                m_streak = (wt == 1) ? m_streak + 1 : 0;
                if (ld_f == 1)
                    m_ben = ((((ir_v >> 11) & 1) & ((nzp_v >> 2) & 1)) |
                             (((ir_v >> 10) & 1) & ((nzp_v >> 1) & 1)) |
                             (((ir_v >> 9) & 1) & (nzp_v & 1))) != 0 ? 1 : 0;
                m_upc = nx;
            end
            tick();
            check_all($sformatf("rand %0d", c), 6'(m_upc), m_ben[0], m_to[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
